// File: rtl/spike_shift_pipe.sv
// spike_shift_pipe: per-channel signed spike-time shifter with
// zero-fill / wrap / clamp edge modes and one registered output stage.
module spike_shift_pipe #(
  parameter int LEN           = 8,
  parameter int CHANNELS      = 4,
  parameter int MAX_SHIFT_MAG = 3,
  parameter int CNT_W         = 16,
  localparam int SW = $clog2(MAX_SHIFT_MAG+1)+1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CHANNELS*LEN-1:0]  in_spikes,
  input  logic [CHANNELS*SW-1:0]   in_shift,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CHANNELS*LEN-1:0]  out_spikes,
  output logic [CHANNELS-1:0]      out_drop,
  output logic [CHANNELS-1:0]      out_range_err,
  output logic [CNT_W-1:0]         drop_cnt
);

  logic                    valid_q;
  logic [CHANNELS*LEN-1:0] spk_q, spk_d;
  logic [CHANNELS-1:0]     drop_q, drop_d;
  logic [CHANNELS-1:0]     rerr_q, rerr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic accept;
  logic wrap_m;
  logic clmp_m;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign wrap_m   = (in_mode == 2'd1);
  assign clmp_m   = (in_mode == 2'd2);

  logic signed [SW-1:0] sh;
  int e;
  int d;

  // Scatter each set source bit to its destination time stamp.
  always_comb begin
    spk_d  = '0;
    drop_d = '0;
    rerr_d = '0;
    sh     = '0;
    e      = 0;
    d      = 0;
    for (int c = 0; c < CHANNELS; c++) begin
      sh = in_shift[c*SW +: SW];
      e  = int'(sh);
      if (e > MAX_SHIFT_MAG) begin
        e         = MAX_SHIFT_MAG;
        rerr_d[c] = 1'b1;
      end else if (e < -MAX_SHIFT_MAG) begin
        e         = -MAX_SHIFT_MAG;
        rerr_d[c] = 1'b1;
      end
      for (int i = 0; i < LEN; i++) begin
        if (in_spikes[c*LEN+i]) begin
          d = i + e;
          unique case (1'b1)
            wrap_m: begin
              if (d < 0)
                d = d + LEN;
              else if (d >= LEN)
                d = d - LEN;
              spk_d[c*LEN+d] = 1'b1;
            end
            clmp_m: begin
              if (d < 0)
                d = 0;
              else if (d >= LEN)
                d = LEN - 1;
              spk_d[c*LEN+d] = 1'b1;
            end
            default: begin
              if (d >= 0 && d < LEN)
                spk_d[c*LEN+d] = 1'b1;
              else
                drop_d[c] = 1'b1;
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && (|drop_d) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      spk_q   <= '0;
      drop_q  <= '0;
      rerr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        valid_q <= 1'b1;
        spk_q   <= spk_d;
        drop_q  <= drop_d;
        rerr_q  <= rerr_d;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid     = valid_q;
  assign out_spikes    = spk_q;
  assign out_drop      = drop_q;
  assign out_range_err = rerr_q;
  assign drop_cnt      = cnt_q;

endmodule

// File: doc/spike_shift_pipe.md
Name: spike_shift_pipe

Overview:
- Multi-channel, pipelined, bi-directional spike-time shifter for the temporal (spike-encoded) datapath.
- Each channel carries a LEN-bit spike vector; bit t set means a spike at time stamp t, and unions of spikes are allowed.
- Each channel takes its own signed binary shift; the batch shares one runtime-selectable edge mode (zero-fill, wrap, clamp).
- Transfers use valid/ready on both sides with one registered output stage; dropped spikes are flagged and counted.

Parameters:
- LEN, 8, spike vector length (time stamps 0..LEN-1), >=2
- CHANNELS, 4, independent channels per transfer, >=1
- MAX_SHIFT_MAG, 3, max legal |shift|, 1..LEN-1
- SW, $clog2(MAX_SHIFT_MAG+1)+1, per-channel signed shift width (derived; do not override)
- CNT_W, 16, width of the drop counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input transfer valid
- in_ready  out  1  block can accept a transfer this cycle
- in_spikes  in  CHANNELS*LEN  channel c = in_spikes[c*LEN +: LEN]; bit c*LEN+t = spike at time t
- in_shift  in  CHANNELS*SW  channel c = in_shift[c*SW +: SW], two's complement; positive = delay (later time)
- in_mode  in  2  0 = zero-fill, 1 = wrap, 2 = clamp, 3 = treated as zero-fill
- out_valid  out  1  output transfer valid
- out_ready  in  1  downstream accepts output
- out_spikes  out  CHANNELS*LEN  shifted vectors, same packing as in_spikes
- out_drop  out  CHANNELS  per channel: at least one spike was discarded
- out_range_err  out  CHANNELS  per channel: shift was outside ±MAX_SHIFT_MAG and was clamped
- drop_cnt  out  CNT_W  saturating count of accepted transfers with any out_drop bit set

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_spikes=0, out_drop=0, out_range_err=0, drop_cnt=0. in_ready=1 on the first cycle after reset.
- Handshake:
  - in_ready = !out_valid || out_ready; this is combinational and carries no dependency on in_valid.
  - A transfer is accepted when in_valid && in_ready.
  - On accept, the output register loads the result and out_valid=1 on the next cycle. Latency is exactly 1 cycle.
  - If out_valid && out_ready && !accept, then out_valid goes to 0 next cycle.
  - While out_valid && !out_ready, every output is held stable and no input is accepted.
  - Accept and drain in the same cycle gives full throughput: one transfer per cycle.
- Shift legalisation, per channel:
  - s = signed in_shift.
  - If s > MAX_SHIFT_MAG, use +MAX_SHIFT_MAG; if s < -MAX_SHIFT_MAG, use -MAX_SHIFT_MAG.
  - In either clamped case out_range_err[c]=1, otherwise 0.
- Shift function, per channel, with e = effective shift and time t = 0..LEN-1:
  - Zero-fill: out[t] = in[t-e] when 0 <= t-e < LEN, else 0. out_drop[c]=1 iff any set input bit maps outside 0..LEN-1.
  - Wrap: out[t] = in[(t-e) mod LEN]. out_drop[c]=0 always.
  - Clamp:
    - Spikes mapping past LEN-1 land on bit LEN-1; spikes mapping below 0 land on bit 0.
    - Coincident spikes OR together.
    - out_drop[c]=0 always.
- e=0 passes the input unchanged in all modes.
- in_mode is sampled only on accept and applies to all channels of that transfer.
- drop_cnt increments by 1 on an accepted transfer whose computed drop vector is non-zero. It holds at 2^CNT_W-1 once it reaches that value.
- Input values are don't-care when in_valid=0; no state changes without an accept.
- Reset asserted mid-operation: the pending output is discarded immediately (out_valid=0 asynchronously) and the counter is cleared.
- Implementation: shift logic is combinational ahead of the single output register; no other storage.

Test Plan (LEN=8, CHANNELS=2, MAX_SHIFT_MAG=3, SW=3, out_ready=1 unless stated; vectors are written MSB = t7):
- Basic delay/advance, mode 0:
  - Stimulus: ch0=8'b0000_0010, shift +2; ch1=8'b0110_0000, shift -1.
  - Response, next cycle: ch0=8'b0000_1000, ch1=8'b0011_0000, out_drop=2'b00, drop_cnt=0.
- Edge modes:
  - Stimulus: ch0=8'b1000_0001, shift +1, applied in each mode.
  - Mode 0 -> 8'b0000_0010, out_drop[0]=1, drop_cnt=1.
  - Mode 1 -> 8'b0000_0011, out_drop[0]=0.
  - Mode 2 -> 8'b1000_0010, out_drop[0]=0.
  - Mode 3 -> same result as mode 0.
- Clamp merge and range error:
  - Stimulus: ch0=8'b0000_0011, shift -1, mode 2 -> 8'b0000_0001.
  - Stimulus: ch1=8'b0001_0000, shift -4 (3'b100) -> shift legalised to -3, giving 8'b0000_0010, out_range_err=2'b10.
- Backpressure:
  - Stimulus: three back-to-back transfers A, B, C, with out_ready=0 for 3 cycles after A's result appears.
  - Response: A is held stable and in_ready=0 during the stall; once out_ready=1, B and then C follow on consecutive cycles; none lost or duplicated.
- Counter saturation (bench build with CNT_W=2):
  - Stimulus: 5 dropping transfers.
  - Response: drop_cnt reads 1, 2, 3, 3, 3.
- Async reset:
  - Stimulus: assert rst mid-cycle while out_valid=1 and drop_cnt=2.
  - Response: out_valid=0, out_spikes=0, out_drop=0, out_range_err=0 and drop_cnt=0 before the next clock edge; in_ready=1 on the first cycle after release.
